// File: rtl/instruction_decode.sv
// RV32I instruction-decode stage: 32x32 register file with x0 hardwired to zero,
// combinational read ports, and the main opcode-to-control decoder.
module instruction_decode #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      Op,
    input  logic [AW-1:0]   Ra,
    input  logic [AW-1:0]   Rb,
    input  logic [AW-1:0]   Rd,
    input  logic [XLEN-1:0] reg_write_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            reg_write,
    output logic            alu_src,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            branch,
    output logic            jump,
    output logic [1:0]      alu_op,
    output logic            illegal_op
);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // x0 has no storage; only x1..x(NREGS-1) are real registers.
    logic [XLEN-1:0] regs [1:NREGS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write && (Rd != '0)) begin
            regs[Rd] <= reg_write_data;
        end
    end

    // No write-to-read bypass: a same-cycle write shows up only after the edge.
    assign rs1_data = (Ra == '0) ? '0 : regs[Ra];
    assign rs2_data = (Rb == '0) ? '0 : regs[Rb];

    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        case (Op)
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = 2'b11;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BR: begin
                branch = 1'b1;
                alu_op = 2'b01;
            end
            OP_JAL, OP_JALR: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                alu_src   = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode: register file behaviour
// around reset and writes, plus the full opcode decode table.
module tb_instruction_decode;

    logic        clk;
    logic        rst_n;
    logic [6:0]  Op;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [4:0]  Rd;
    logic [31:0] reg_write_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        reg_write;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic [1:0]  alu_op;
    logic        illegal_op;

    int n_checks;
    int n_fail;

    instruction_decode dut (
        .clk(clk),
        .rst_n(rst_n),
        .Op(Op),
        .Ra(Ra),
        .Rb(Rb),
        .Rd(Rd),
        .reg_write_data(reg_write_data),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .reg_write(reg_write),
        .alu_src(alu_src),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_to_reg(mem_to_reg),
        .branch(branch),
        .jump(jump),
        .alu_op(alu_op),
        .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector: {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, alu_op, illegal_op}
    logic [9:0] ctrl;
    assign ctrl = {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, alu_op, illegal_op};

    // Inputs change 1 time unit after a rising edge, well clear of the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        Op = 7'b0110011;
        Rd = 5'd3;
        reg_write_data = 32'hCAFEF00D;
        Ra = 5'd0;
        Rb = 5'd0;
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 1; i < 32; i++) begin
            Ra = 5'(i);
            Rb = 5'(i);
            #1;
            n_checks++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read x%0d: rs1=%h rs2=%h expected 0", i, rs1_data, rs2_data);
            end
        end
        // An enabled write during reset must be ignored.
        step();
        step();
        rst_n = 1'b1;
        Op = 7'b0000000;
        Rd = 5'd1;
        reg_write_data = 32'h0000DEAD;
        #1;
        n_checks++;
        if (illegal_op !== 1'b1 || reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_illegal: illegal_op=%b reg_write=%b expected 1/0", illegal_op, reg_write);
        end
        step();
        Ra = 5'd1;
        Rb = 5'd3;
        #1;
        n_checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_no_write: x1=%h x3=%h expected 0", rs1_data, rs2_data);
        end
    endtask

    task automatic test_rtype();
        Op = 7'b0110011;
        Rd = 5'd2;
        reg_write_data = 32'h000000F0;
        Rb = 5'd2;
        #1;
        n_checks++;
        if (rs2_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rtype_pre_edge: rs2=%h expected 0", rs2_data);
        end
        step();
        Ra = 5'd4;
        Rb = 5'd2;
        #1;
        n_checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h000000F0) begin
            n_fail++;
            $display("FAIL rtype_read: rs1=%h rs2=%h expected 0/000000f0", rs1_data, rs2_data);
        end
        n_checks++;
        if (reg_write !== 1'b1 || alu_op !== 2'b10) begin
            n_fail++;
            $display("FAIL rtype_ctrl: reg_write=%b alu_op=%b expected 1/10", reg_write, alu_op);
        end
    endtask

    task automatic test_store();
        Op = 7'b0100011;
        Rd = 5'd2;
        reg_write_data = 32'h12345678;
        step();
        step();
        step();
        Rb = 5'd2;
        #1;
        n_checks++;
        if (rs2_data !== 32'h000000F0) begin
            n_fail++;
            $display("FAIL store_no_write: rs2=%h expected 000000f0", rs2_data);
        end
        n_checks++;
        if (mem_write !== 1'b1 || alu_src !== 1'b1 || reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ctrl: mem_write=%b alu_src=%b reg_write=%b expected 1/1/0",
                     mem_write, alu_src, reg_write);
        end
    endtask

    task automatic test_x0();
        Op = 7'b0110011;
        Rd = 5'd0;
        reg_write_data = 32'hFFFFFFFF;
        step();
        Ra = 5'd0;
        Rb = 5'd0;
        #1;
        n_checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_immutable: rs1=%h rs2=%h expected 0", rs1_data, rs2_data);
        end
    endtask

    task automatic test_back_to_back();
        Op = 7'b0010011;
        for (int i = 0; i < 3; i++) begin
            Rd = 5'(10 + i);
            reg_write_data = 32'h1000 + 32'(i);
            step();
        end
        Op = 7'b1100011;
        for (int i = 0; i < 3; i++) begin
            Ra = 5'(10 + i);
            Rb = 5'(12 - i);
            #1;
            n_checks++;
            if (rs1_data !== 32'h1000 + 32'(i) || rs2_data !== 32'h1002 - 32'(i)) begin
                n_fail++;
                $display("FAIL back_to_back x%0d: rs1=%h rs2=%h expected %h/%h",
                         10 + i, rs1_data, rs2_data, 32'h1000 + 32'(i), 32'h1002 - 32'(i));
            end
        end
    endtask

    task automatic test_decode_sweep();
        logic [6:0] ops [12];
        logic [9:0] exp_ctrl [12];
        Rd = 5'd0;
        ops[0]  = 7'b0110011; exp_ctrl[0]  = 10'b1000000_10_0;
        ops[1]  = 7'b0010011; exp_ctrl[1]  = 10'b1100000_11_0;
        ops[2]  = 7'b0000011; exp_ctrl[2]  = 10'b1110100_00_0;
        ops[3]  = 7'b0100011; exp_ctrl[3]  = 10'b0101000_00_0;
        ops[4]  = 7'b1100011; exp_ctrl[4]  = 10'b0000010_01_0;
        ops[5]  = 7'b1101111; exp_ctrl[5]  = 10'b1100001_00_0;
        ops[6]  = 7'b1100111; exp_ctrl[6]  = 10'b1100001_00_0;
        ops[7]  = 7'b0110111; exp_ctrl[7]  = 10'b1100000_00_0;
        ops[8]  = 7'b0010111; exp_ctrl[8]  = 10'b1100000_00_0;
        ops[9]  = 7'b0000000; exp_ctrl[9]  = 10'b0000000_00_1;
        ops[10] = 7'b1111111; exp_ctrl[10] = 10'b0000000_00_1;
        ops[11] = 7'b0110001; exp_ctrl[11] = 10'b0000000_00_1;
        for (int i = 0; i < 12; i++) begin
            Op = ops[i];
            #1;
            n_checks++;
            if (ctrl !== exp_ctrl[i]) begin
                n_fail++;
                $display("FAIL decode op=%b: ctrl=%b expected %b", ops[i], ctrl, exp_ctrl[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        Op = 7'b0110011;
        Rd = 5'd5;
        reg_write_data = 32'hA5A5A5A5;
        step();
        Rd = 5'd0;
        Ra = 5'd5;
        #1;
        n_checks++;
        if (rs1_data !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL async_preload: rs1=%h expected a5a5a5a5", rs1_data);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_clear: rs1=%h expected 0", rs1_data);
        end
        n_checks++;
        if (reg_write !== 1'b1 || alu_op !== 2'b10 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL async_decode: reg_write=%b alu_op=%b illegal_op=%b expected 1/10/0",
                     reg_write, alu_op, illegal_op);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_stays_clear: rs1=%h expected 0", rs1_data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b1;
        Op = 7'b0;
        Ra = 5'd0;
        Rb = 5'd0;
        Rd = 5'd0;
        reg_write_data = 32'h0;
        test_reset();
        test_rtype();
        test_store();
        test_x0();
        test_back_to_back();
        test_decode_sweep();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
